// File: rtl/pattern_stepper.sv
// Sweeps a 4-bit code through 0..F (optionally from a loaded start value) for a
// downstream combinational stage, holding each code for DWELL cycles and until it has been consumed.
module pattern_stepper #(
    parameter int unsigned DWELL = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic       loop,
    input  logic       load_en,
    input  logic [3:0] load_val,
    input  logic       code_ready,
    output logic [3:0] code,
    output logic       code_valid,
    output logic       busy,
    output logic       done,
    output logic [7:0] wrap_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [7:0] RELOAD = 8'(DWELL - 1);

    state_t     state;
    logic [7:0] dwell_cnt;

    // NOTE: every register is written with <= so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            code       <= 4'h0;
            code_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wrap_cnt   <= 8'd0;
            dwell_cnt  <= 8'd0;
        end else if (stop) begin
            // Abort wins over start, pause and advance; the wrap count is kept for inspection.
            state      <= IDLE;
            code       <= 4'h0;
            code_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            dwell_cnt  <= 8'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= RUN;
                        code       <= load_en ? load_val : 4'h0;
                        dwell_cnt  <= RELOAD;
                        wrap_cnt   <= 8'd0;
                        code_valid <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                    end
                end
                RUN: begin
                    if (!pause) begin
                        if (dwell_cnt != 8'd0) begin
                            dwell_cnt <= dwell_cnt - 8'd1;
                        end else if (code_ready) begin
                            if (code != 4'hF) begin
                                code      <= code + 4'h1;
                                dwell_cnt <= RELOAD;
                            end else if (loop) begin
                                code      <= 4'h0;
                                dwell_cnt <= RELOAD;
                                if (wrap_cnt != 8'hFF) begin
                                    wrap_cnt <= wrap_cnt + 8'd1;
                                end
                            end else begin
                                state      <= DONE;
                                code_valid <= 1'b0;
                                busy       <= 1'b0;
                                done       <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
